hazard_issue_ctrl: RTL

- Issue/hazard controller sitting between fetch and the decode/execute stage.
- Keeps a per-register scoreboard of outstanding writes (long-latency ops, plus last-cycle short ops).
- Gates instruction issue with a valid/ready handshake and flushes the front end after a PC redirect.
- Drains outstanding long ops on request (fence-style).

---
 rtl/hazard_issue_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/hazard_issue_ctrl.sv
// Issue/hazard controller: long-op register scoreboard, issue gating, redirect flush and drain.
// Build option HAZARD_FORWARD_EN: the datapath forwards the previous short-op result.
module hazard_issue_ctrl #(
  parameter int NUM_REGS     = 32,
  parameter int REG_AW       = 5,
  parameter int FLUSH_CYCLES = 2,
  parameter int MAX_PENDING  = 4,
  localparam int CNT_W       = $clog2(MAX_PENDING + 1)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_issue_valid,
  output logic                o_issue_ready,
  input  logic [REG_AW-1:0]   i_rs1,
  input  logic [REG_AW-1:0]   i_rs2,
  input  logic                i_rs1_used,
  input  logic                i_rs2_used,
  input  logic [REG_AW-1:0]   i_rd,
  input  logic                i_rd_write,
  input  logic                i_long_op,
  input  logic                i_redirect,
  input  logic                i_drain,
  input  logic                i_wb_valid,
  input  logic [REG_AW-1:0]   i_wb_rd,
  output logic                o_flush,
  output logic                o_stall,
  output logic [NUM_REGS-1:0] o_busy,
  output logic [CNT_W-1:0]    o_pending_cnt,
  output logic [1:0]          o_state
);

  localparam int FCNT_W = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t              state;
  logic [NUM_REGS-1:0] busy;
  logic [CNT_W-1:0]    pending_cnt;
  logic                trk_valid;
  logic [REG_AW-1:0]   trk_rd;
  logic [FCNT_W-1:0]   flush_cnt;
  logic                flush_q;

  logic                raw_hazard;
  logic                waw_hazard;
  logic                struct_hazard;
  logic                short_hazard;
  logic                issue_ready;
  logic                accept;
  logic                long_accept;
  logic                wb_take;
  logic [NUM_REGS-1:0] busy_set;
  logic [NUM_REGS-1:0] busy_clr;

  // Handshake: an instruction issues on a cycle where i_issue_valid & o_issue_ready;
  // decode must hold its operands stable while valid is high and ready is low.
  assign raw_hazard    = (i_rs1_used & busy[i_rs1]) | (i_rs2_used & busy[i_rs2]);
  assign waw_hazard    = i_rd_write & busy[i_rd];
  assign struct_hazard = i_long_op & (pending_cnt == CNT_W'(MAX_PENDING));

`ifdef HAZARD_FORWARD_EN
  logic short_unused;
  assign short_hazard = 1'b0;
  assign short_unused = ^{trk_valid, trk_rd};
`else
  // Previous short result is not yet readable from the register file.
  assign short_hazard = trk_valid &
                        ((i_rs1_used & (i_rs1 == trk_rd)) | (i_rs2_used & (i_rs2 == trk_rd)));
`endif

  assign issue_ready = ~i_rst & (state == ST_RUN) &
                       ~(raw_hazard | waw_hazard | struct_hazard) & ~short_hazard;
  assign accept      = i_issue_valid & issue_ready;
  assign long_accept = accept & i_long_op;
  assign wb_take     = i_wb_valid & (pending_cnt != '0);

  always_comb begin
    busy_set = '0;
    busy_clr = '0;
    if (long_accept & i_rd_write & (i_rd != '0)) busy_set[i_rd] = 1'b1;
    if (wb_take & (i_wb_rd != '0))               busy_clr[i_wb_rd] = 1'b1;
  end

  // Scoreboard and short-write tracker; a same-cycle set beats the clear.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      busy        <= '0;
      pending_cnt <= '0;
      trk_valid   <= 1'b0;
      trk_rd      <= '0;
    end else begin
      busy <= (busy & ~busy_clr) | busy_set;
      case ({long_accept, wb_take})
        2'b10:   pending_cnt <= pending_cnt + CNT_W'(1);
        2'b01:   pending_cnt <= pending_cnt - CNT_W'(1);
        default: pending_cnt <= pending_cnt;
      endcase
      trk_valid <= accept & ~i_long_op & i_rd_write & (i_rd != '0);
      trk_rd    <= i_rd;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= ST_RUN;
      flush_cnt <= '0;
      flush_q   <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (accept & i_redirect) begin
            state     <= ST_FLUSH;
            flush_cnt <= FCNT_W'(FLUSH_CYCLES);
            flush_q   <= 1'b1;
          end else if (i_drain & ~accept) begin
            state <= ST_DRAIN;
          end
        end
        ST_FLUSH: begin
          if (flush_cnt == FCNT_W'(1)) begin
            state     <= ST_RUN;
            flush_cnt <= '0;
            flush_q   <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt - FCNT_W'(1);
          end
        end
        ST_DRAIN: begin
          if ((pending_cnt == '0) | ((pending_cnt == CNT_W'(1)) & i_wb_valid))
            state <= ST_RUN;
        end
        default: begin
          state   <= ST_RUN;
          flush_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_issue_ready = issue_ready;
  assign o_stall       = i_issue_valid & ~issue_ready;
  assign o_flush       = flush_q;
  assign o_busy        = busy;
  assign o_pending_cnt = pending_cnt;
  assign o_state       = state;

endmodule
